// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : EX/MEM/WB slot tracker producing load-use stall, EX bubble
//               insertion and EX operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic [15:0] ex_instr,
    output logic        ex_valid,
    output logic [2:0]  ForwardA,
    output logic [2:0]  ForwardB,
    output logic        stall
);

    localparam logic [15:0] c_BUBBLE_INSTR = 16'h0000;
    localparam logic [3:0]  c_REG_ZERO     = 4'd0;

    logic [15:0] r_ex_instr_q,    w_ex_instr_d;
    logic [3:0]  r_ex_rs_q,       w_ex_rs_d;
    logic [3:0]  r_ex_rt_q,       w_ex_rt_d;
    logic [3:0]  r_ex_rd_q,       w_ex_rd_d;
    logic        r_ex_use_rs_q,   w_ex_use_rs_d;
    logic        r_ex_use_rt_q,   w_ex_use_rt_d;
    logic        r_ex_regwrite_q, w_ex_regwrite_d;
    logic        r_ex_memread_q,  w_ex_memread_d;
    logic        r_ex_valid_q,    w_ex_valid_d;
    logic [3:0]  r_mem_rd_q;
    logic        r_mem_regwrite_q;
    logic        r_mem_valid_q;
    logic [3:0]  r_wb_rd_q;
    logic        r_wb_regwrite_q;
    logic        r_wb_valid_q;

    logic w_load_use;
    logic w_mem_wr;
    logic w_wb_wr;
    logic w_fa_mem, w_fa_wb;
    logic w_fb_mem, w_fb_wb;

    always_comb begin
        w_load_use = id_valid & r_ex_valid_q & r_ex_memread_q
                   & (r_ex_rd_q != c_REG_ZERO)
                   & ((id_use_rs & (id_rs == r_ex_rd_q))
                    | (id_use_rt & (id_rt == r_ex_rd_q)));

        // Bubble by default; a real instruction enters only when neither flushed nor held.
        w_ex_instr_d    = c_BUBBLE_INSTR;
        w_ex_rs_d       = c_REG_ZERO;
        w_ex_rt_d       = c_REG_ZERO;
        w_ex_rd_d       = c_REG_ZERO;
        w_ex_use_rs_d   = 1'b0;
        w_ex_use_rt_d   = 1'b0;
        w_ex_regwrite_d = 1'b0;
        w_ex_memread_d  = 1'b0;
        w_ex_valid_d    = 1'b0;
        if (!(flush || w_load_use)) begin
            w_ex_instr_d    = id_instr;
            w_ex_rs_d       = id_rs;
            w_ex_rt_d       = id_rt;
            w_ex_rd_d       = id_rd;
            w_ex_use_rs_d   = id_use_rs;
            w_ex_use_rt_d   = id_use_rt;
            w_ex_regwrite_d = id_regwrite & id_valid;
            w_ex_memread_d  = id_memread & id_valid;
            w_ex_valid_d    = id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_instr_q     <= c_BUBBLE_INSTR;
            r_ex_rs_q        <= c_REG_ZERO;
            r_ex_rt_q        <= c_REG_ZERO;
            r_ex_rd_q        <= c_REG_ZERO;
            r_ex_use_rs_q    <= 1'b0;
            r_ex_use_rt_q    <= 1'b0;
            r_ex_regwrite_q  <= 1'b0;
            r_ex_memread_q   <= 1'b0;
            r_ex_valid_q     <= 1'b0;
            r_mem_rd_q       <= c_REG_ZERO;
            r_mem_regwrite_q <= 1'b0;
            r_mem_valid_q    <= 1'b0;
            r_wb_rd_q        <= c_REG_ZERO;
            r_wb_regwrite_q  <= 1'b0;
            r_wb_valid_q     <= 1'b0;
        end else begin
            r_ex_instr_q     <= w_ex_instr_d;
            r_ex_rs_q        <= w_ex_rs_d;
            r_ex_rt_q        <= w_ex_rt_d;
            r_ex_rd_q        <= w_ex_rd_d;
            r_ex_use_rs_q    <= w_ex_use_rs_d;
            r_ex_use_rt_q    <= w_ex_use_rt_d;
            r_ex_regwrite_q  <= w_ex_regwrite_d;
            r_ex_memread_q   <= w_ex_memread_d;
            r_ex_valid_q     <= w_ex_valid_d;
            r_mem_rd_q       <= r_ex_rd_q;
            r_mem_regwrite_q <= r_ex_regwrite_q;
            r_mem_valid_q    <= r_ex_valid_q;
            r_wb_rd_q        <= r_mem_rd_q;
            r_wb_regwrite_q  <= r_mem_regwrite_q;
            r_wb_valid_q     <= r_mem_valid_q;
        end
    end

    // A producer qualifies only if it is live, writes, and targets a non-zero register.
    always_comb begin
        w_mem_wr = r_mem_valid_q & r_mem_regwrite_q & (r_mem_rd_q != c_REG_ZERO);
        w_wb_wr  = r_wb_valid_q & r_wb_regwrite_q & (r_wb_rd_q != c_REG_ZERO);
        w_fa_mem = r_ex_valid_q & r_ex_use_rs_q & w_mem_wr & (r_mem_rd_q == r_ex_rs_q);
        w_fa_wb  = r_ex_valid_q & r_ex_use_rs_q & w_wb_wr & (r_wb_rd_q == r_ex_rs_q) & ~w_fa_mem;
        w_fb_mem = r_ex_valid_q & r_ex_use_rt_q & w_mem_wr & (r_mem_rd_q == r_ex_rt_q);
        w_fb_wb  = r_ex_valid_q & r_ex_use_rt_q & w_wb_wr & (r_wb_rd_q == r_ex_rt_q) & ~w_fb_mem;
    end

    assign ForwardA = {1'b0, w_fa_mem, w_fa_wb};
    assign ForwardB = {1'b0, w_fb_mem, w_fb_wb};
    assign stall    = w_load_use & ~flush;
    assign ex_instr = r_ex_instr_q;
    assign ex_valid = r_ex_valid_q;

endmodule
`default_nettype wire
